repairmb_partner_ctrl: RTL and testbench

- Parametrised successor of the MBINIT.REPAIRMB partner-side responder.
- Answers the link partner's REPAIRMB sideband requests: start, apply_degrade (repeatable) and end.
- Evaluates the received functional-lane mask in-line, so no separate checker instance is needed.
- Adds a configurable lane-mask width, a degrade-iteration limit, a state timeout and a sticky train-error exit.
- Sits between the sideband RX/TX message muxes and the MBINIT sequencer, after REVERSALMB.

---
 rtl/repairmb_partner_ctrl_if.sv | 39 +++
 rtl/repairmb_partner_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_repairmb_partner_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/repairmb_partner_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : repairmb_partner_ctrl_if
// Brief    : Sideband / sequencer signal bundle for the REPAIRMB partner responder.
// Revision : 1.0 - initial release
// ============================================================================
interface repairmb_partner_ctrl_if #(
  parameter int LANE_MASK_W = 2
);
  logic                   i_en;
  logic                   i_busy_sideband;
  logic                   i_falling_edge_busy;
  logic [3:0]             i_rx_msg;
  logic                   i_msg_valid;
  logic [LANE_MASK_W-1:0] i_lane_mask;
  logic                   i_done_repeater;
  logic [3:0]             o_tx_msg;
  logic                   o_tx_valid;
  logic [LANE_MASK_W-1:0] o_lane_mask;
  logic                   o_start_repeater;
  logic                   o_end;
  logic                   o_train_error;
  logic                   o_timeout;

  modport master (
    output i_en, i_busy_sideband, i_falling_edge_busy, i_rx_msg, i_msg_valid,
           i_lane_mask, i_done_repeater,
    input  o_tx_msg, o_tx_valid, o_lane_mask, o_start_repeater, o_end,
           o_train_error, o_timeout
  );

  modport slave (
    input  i_en, i_busy_sideband, i_falling_edge_busy, i_rx_msg, i_msg_valid,
           i_lane_mask, i_done_repeater,
    output o_tx_msg, o_tx_valid, o_lane_mask, o_start_repeater, o_end,
           o_train_error, o_timeout
  );
endinterface
`default_nettype wire

// File: rtl/repairmb_partner_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : repairmb_partner_ctrl
// Brief    : MBINIT.REPAIRMB partner-side responder with in-line mask check.
// Revision : 1.0 - initial release
// ============================================================================
module repairmb_partner_ctrl #(
  parameter int LANE_MASK_W = 2,
  parameter int MIN_GROUPS  = 1,
  parameter int MAX_DEGRADE = 3,
  parameter int TO_W        = 20,
  parameter int TO_CYCLES   = 800000
) (
  input  logic                    CLK,
  input  logic                    rst,
  repairmb_partner_ctrl_if.slave  sb
);
  localparam logic [3:0] ST_IDLE            = 4'd0;
  localparam logic [3:0] ST_WAIT_START_REQ  = 4'd1;
  localparam logic [3:0] ST_WAIT_SB_START   = 4'd2;
  localparam logic [3:0] ST_SEND_START_RESP = 4'd3;
  localparam logic [3:0] ST_WAIT_REQ        = 4'd4;
  localparam logic [3:0] ST_CHECK           = 4'd5;
  localparam logic [3:0] ST_WAIT_SB_DEG     = 4'd6;
  localparam logic [3:0] ST_SEND_DEG_RESP   = 4'd7;
  localparam logic [3:0] ST_RUN_REP         = 4'd8;
  localparam logic [3:0] ST_WAIT_SB_END     = 4'd9;
  localparam logic [3:0] ST_SEND_END_RESP   = 4'd10;
  localparam logic [3:0] ST_DONE            = 4'd11;
  localparam logic [3:0] ST_ERROR           = 4'd12;

  localparam logic [3:0] MSG_START_REQ  = 4'd1;
  localparam logic [3:0] MSG_START_RESP = 4'd2;
  localparam logic [3:0] MSG_END_REQ    = 4'd3;
  localparam logic [3:0] MSG_END_RESP   = 4'd4;
  localparam logic [3:0] MSG_DEG_REQ    = 4'd5;
  localparam logic [3:0] MSG_DEG_RESP   = 4'd6;

  localparam int              DEG_W   = $clog2(MAX_DEGRADE + 2);
  localparam int              PC_W    = $clog2(LANE_MASK_W + 1);
  localparam logic [DEG_W-1:0] DEG_MAX = DEG_W'(MAX_DEGRADE);
  localparam logic [PC_W-1:0]  PC_MIN  = PC_W'(MIN_GROUPS);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TO_CYCLES - 1);

  logic [3:0]             state, next;
  logic [LANE_MASK_W-1:0] cap_mask, lane_q;
  logic [DEG_W-1:0]       deg_cnt;
  logic [TO_W-1:0]        to_cnt;
  logic [PC_W-1:0]        ones;
  logic                   cont, rep, pend;
  logic                   live_start, live_end, live_deg, running, timeout_hit;
  logic                   all_ones, chk_err;
  logic [3:0]             tx_msg_d, tx_msg_q;
  logic                   tx_valid_d, start_rep_d, end_d, err_d, to_d;
  logic                   tx_valid_q, start_rep_q, end_q, err_q, to_q;

  assign live_start  = sb.i_msg_valid && (sb.i_rx_msg == MSG_START_REQ);
  assign live_end    = sb.i_msg_valid && (sb.i_rx_msg == MSG_END_REQ);
  assign live_deg    = sb.i_msg_valid && (sb.i_rx_msg == MSG_DEG_REQ);
  assign running     = (state != ST_IDLE) && (state != ST_DONE) && (state != ST_ERROR);
  assign timeout_hit = running && (to_cnt == TO_LAST);

  always_comb begin
    ones = '0;
    for (int i = 0; i < LANE_MASK_W; i++) ones = ones + PC_W'(cap_mask[i]);
  end

  assign all_ones = &cap_mask;
  assign chk_err  = (deg_cnt > DEG_MAX) || (!all_ones && (ones < PC_MIN));

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next;
  end

  // Priority: enable drop, then timeout, then message/handshake progress.
  always_comb begin
    next = state;
    if (!sb.i_en) next = ST_IDLE;
    else if (timeout_hit) next = ST_ERROR;
    else begin
      case (state)
        ST_IDLE:            next = ST_WAIT_START_REQ;
        ST_WAIT_START_REQ:  if (live_start) next = ST_WAIT_SB_START;
        ST_WAIT_SB_START:   if (!sb.i_busy_sideband) next = ST_SEND_START_RESP;
        ST_SEND_START_RESP: if (sb.i_falling_edge_busy) next = ST_WAIT_REQ;
        ST_WAIT_REQ: begin
          if ((live_end || pend) && cont) next = ST_WAIT_SB_END;
          else if (live_deg)              next = ST_CHECK;
        end
        ST_CHECK:           next = chk_err ? ST_ERROR : ST_WAIT_SB_DEG;
        ST_WAIT_SB_DEG:     if (!sb.i_busy_sideband) next = ST_SEND_DEG_RESP;
        ST_SEND_DEG_RESP: begin
          if (sb.i_falling_edge_busy) begin
            if (rep)                           next = ST_RUN_REP;
            else if ((pend || live_end) && cont) next = ST_WAIT_SB_END;
            else                               next = ST_WAIT_REQ;
          end
        end
        ST_RUN_REP:         if (sb.i_done_repeater) next = ST_WAIT_REQ;
        ST_WAIT_SB_END:     if (!sb.i_busy_sideband) next = ST_SEND_END_RESP;
        ST_SEND_END_RESP:   if (sb.i_falling_edge_busy) next = ST_DONE;
        ST_DONE:            next = ST_DONE;
        ST_ERROR:           next = ST_ERROR;
        default:            next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    tx_msg_d    = 4'd0;
    tx_valid_d  = 1'b0;
    case (next)
      ST_SEND_START_RESP: begin tx_msg_d = MSG_START_RESP; tx_valid_d = 1'b1; end
      ST_SEND_DEG_RESP:   begin tx_msg_d = MSG_DEG_RESP;   tx_valid_d = 1'b1; end
      ST_SEND_END_RESP:   begin tx_msg_d = MSG_END_RESP;   tx_valid_d = 1'b1; end
      default: ;
    endcase
    start_rep_d = (next == ST_RUN_REP) && (state != ST_RUN_REP);
    end_d       = (next == ST_DONE);
    err_d       = (next == ST_ERROR);
    to_d        = (next == ST_ERROR) && (timeout_hit || to_q);
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      tx_msg_q    <= 4'd0;
      tx_valid_q  <= 1'b0;
      start_rep_q <= 1'b0;
      end_q       <= 1'b0;
      err_q       <= 1'b0;
      to_q        <= 1'b0;
    end else begin
      tx_msg_q    <= tx_msg_d;
      tx_valid_q  <= tx_valid_d;
      start_rep_q <= start_rep_d;
      end_q       <= end_d;
      err_q       <= err_d;
      to_q        <= to_d;
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      cap_mask <= '0;
      lane_q   <= '1;
      deg_cnt  <= '0;
      to_cnt   <= '0;
      cont     <= 1'b0;
      rep      <= 1'b0;
      pend     <= 1'b0;
    end else begin
      to_cnt <= (!running || (next != state)) ? '0 : to_cnt + 1'b1;
      if (state == ST_IDLE) begin
        deg_cnt <= '0;
        cont    <= 1'b0;
        rep     <= 1'b0;
      end
      if ((state == ST_WAIT_REQ) && (next == ST_CHECK)) begin
        cap_mask <= sb.i_lane_mask;
        if (deg_cnt != '1) deg_cnt <= deg_cnt + 1'b1;
      end
      if ((state == ST_CHECK) && (next == ST_WAIT_SB_DEG)) begin
        cont <= all_ones;
        rep  <= !all_ones;
        if (!all_ones) lane_q <= cap_mask;
      end
      if ((state == ST_RUN_REP) && (next == ST_WAIT_REQ)) rep <= 1'b0;
      // An end_req seen while a degrade is in flight is replayed from WAIT_REQ.
      if ((next == ST_IDLE) || ((next == ST_WAIT_SB_END) && (state != ST_WAIT_SB_END)))
        pend <= 1'b0;
      else if (live_end && ((state == ST_CHECK) || (state == ST_WAIT_SB_DEG) ||
                            (state == ST_SEND_DEG_RESP)))
        pend <= 1'b1;
    end
  end

  assign sb.o_tx_msg         = tx_msg_q;
  assign sb.o_tx_valid       = tx_valid_q;
  assign sb.o_lane_mask      = lane_q;
  assign sb.o_start_repeater = start_rep_q;
  assign sb.o_end            = end_q;
  assign sb.o_train_error    = err_q;
  assign sb.o_timeout        = to_q;
endmodule
`default_nettype wire

// File: tb/tb_repairmb_partner_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_repairmb_partner_ctrl
// Brief    : Directed vector bench for the REPAIRMB partner responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_repairmb_partner_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   total  = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  repairmb_partner_ctrl_if #(.LANE_MASK_W(2)) bus ();

  repairmb_partner_ctrl #(
    .LANE_MASK_W(2), .MIN_GROUPS(1), .MAX_DEGRADE(3), .TO_W(20), .TO_CYCLES(16)
  ) dut (
    .CLK(clk),
    .rst(rst),
    .sb (bus.slave)
  );

  typedef struct {
    logic       en, busy, feb;
    logic [3:0] msg;
    logic       val;
    logic [1:0] mask;
    logic       done;
    logic [3:0] txm;
    logic       txv;
    logic [1:0] lane;
    logic       sr, ed, er, to;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic en, busy, feb, input logic [3:0] msg,
                              input logic val, input logic [1:0] mask, input logic done,
                              input logic [3:0] txm, input logic txv, input logic [1:0] lane,
                              input logic sr, ed, er, to);
    vec_t v;
    v.en = en; v.busy = busy; v.feb = feb; v.msg = msg; v.val = val; v.mask = mask;
    v.done = done; v.txm = txm; v.txv = txv; v.lane = lane; v.sr = sr; v.ed = ed;
    v.er = er; v.to = to;
    vecs.push_back(v);
  endfunction

  task automatic cyc(input logic en, busy, feb, input logic [3:0] msg, input logic val,
                     input logic [1:0] mask, input logic done);
    bus.i_en = en; bus.i_busy_sideband = busy; bus.i_falling_edge_busy = feb;
    bus.i_rx_msg = msg; bus.i_msg_valid = val; bus.i_lane_mask = mask;
    bus.i_done_repeater = done;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [3:0] txm, input logic txv,
                     input logic [1:0] lane, input logic sr, ed, er, to);
    logic [10:0] exp_v, act_v;
    exp_v = {txm, txv, lane, sr, ed, er, to};
    act_v = {bus.o_tx_msg, bus.o_tx_valid, bus.o_lane_mask, bus.o_start_repeater,
             bus.o_end, bus.o_train_error, bus.o_timeout};
    total++;
    if (act_v === exp_v) passed++;
    else $display("FAIL %s: got {txm,txv,lane,sr,end,err,to}=%b want %b", nm, act_v, exp_v);
  endtask

  // Runs IDLE -> WAIT_REQ (start handshake) with no checks.
  task automatic to_wait_req();
    cyc(1, 1, 0, 4'd0, 0, 2'b00, 0);
    cyc(1, 1, 0, 4'd1, 1, 2'b00, 0);
    cyc(1, 0, 0, 4'd0, 0, 2'b00, 0);
    cyc(1, 1, 1, 4'd0, 0, 2'b00, 0);
  endtask

  initial begin
    // Happy path: start, degrade 11, end.
    add(1,1,0,4'd0,0,2'b00,0, 4'd0,0,2'b11,0,0,0,0);
    add(1,1,0,4'd1,1,2'b00,0, 4'd0,0,2'b11,0,0,0,0);
    add(1,0,0,4'd0,0,2'b00,0, 4'd2,1,2'b11,0,0,0,0);
    add(1,1,0,4'd0,0,2'b00,0, 4'd2,1,2'b11,0,0,0,0);
    add(1,1,1,4'd0,0,2'b00,0, 4'd0,0,2'b11,0,0,0,0);
    add(1,1,0,4'd5,1,2'b11,0, 4'd0,0,2'b11,0,0,0,0);
    add(1,1,0,4'd0,0,2'b00,0, 4'd0,0,2'b11,0,0,0,0);
    add(1,1,0,4'd0,0,2'b00,0, 4'd0,0,2'b11,0,0,0,0);
    add(1,0,0,4'd0,0,2'b00,0, 4'd6,1,2'b11,0,0,0,0);
    add(1,1,1,4'd0,0,2'b00,0, 4'd0,0,2'b11,0,0,0,0);
    add(1,1,0,4'd3,1,2'b00,0, 4'd0,0,2'b11,0,0,0,0);
    add(1,0,0,4'd0,0,2'b00,0, 4'd4,1,2'b11,0,0,0,0);
    add(1,1,1,4'd0,0,2'b00,0, 4'd0,0,2'b11,0,1,0,0);
    add(1,1,0,4'd0,0,2'b00,0, 4'd0,0,2'b11,0,1,0,0);
    add(0,1,0,4'd0,0,2'b00,0, 4'd0,0,2'b11,0,0,0,0);
    // Degrade to 01, repeater, dropped end_req, degrade 11, end.
    add(1,1,0,4'd0,0,2'b00,0, 4'd0,0,2'b11,0,0,0,0);
    add(1,1,0,4'd1,1,2'b00,0, 4'd0,0,2'b11,0,0,0,0);
    add(1,0,0,4'd0,0,2'b00,0, 4'd2,1,2'b11,0,0,0,0);
    add(1,1,1,4'd0,0,2'b00,0, 4'd0,0,2'b11,0,0,0,0);
    add(1,1,0,4'd5,1,2'b01,0, 4'd0,0,2'b11,0,0,0,0);
    add(1,1,0,4'd0,0,2'b00,0, 4'd0,0,2'b01,0,0,0,0);
    add(1,0,0,4'd0,0,2'b00,0, 4'd6,1,2'b01,0,0,0,0);
    add(1,1,1,4'd0,0,2'b00,0, 4'd0,0,2'b01,1,0,0,0);
    add(1,1,0,4'd0,0,2'b00,0, 4'd0,0,2'b01,0,0,0,0);
    add(1,1,0,4'd0,0,2'b00,1, 4'd0,0,2'b01,0,0,0,0);
    add(1,1,0,4'd3,1,2'b00,0, 4'd0,0,2'b01,0,0,0,0);
    add(1,1,0,4'd5,1,2'b11,0, 4'd0,0,2'b01,0,0,0,0);
    add(1,1,0,4'd0,0,2'b00,0, 4'd0,0,2'b01,0,0,0,0);
    add(1,0,0,4'd0,0,2'b00,0, 4'd6,1,2'b01,0,0,0,0);
    add(1,1,1,4'd0,0,2'b00,0, 4'd0,0,2'b01,0,0,0,0);
    add(1,1,0,4'd3,1,2'b00,0, 4'd0,0,2'b01,0,0,0,0);
    add(1,0,0,4'd0,0,2'b00,0, 4'd4,1,2'b01,0,0,0,0);
    add(1,1,1,4'd0,0,2'b00,0, 4'd0,0,2'b01,0,1,0,0);
    add(0,1,0,4'd0,0,2'b00,0, 4'd0,0,2'b01,0,0,0,0);
    // Early end during SEND_DEG_RESP.
    add(1,1,0,4'd0,0,2'b00,0, 4'd0,0,2'b01,0,0,0,0);
    add(1,1,0,4'd1,1,2'b00,0, 4'd0,0,2'b01,0,0,0,0);
    add(1,0,0,4'd0,0,2'b00,0, 4'd2,1,2'b01,0,0,0,0);
    add(1,1,1,4'd0,0,2'b00,0, 4'd0,0,2'b01,0,0,0,0);
    add(1,1,0,4'd5,1,2'b11,0, 4'd0,0,2'b01,0,0,0,0);
    add(1,1,0,4'd0,0,2'b00,0, 4'd0,0,2'b01,0,0,0,0);
    add(1,0,0,4'd0,0,2'b00,0, 4'd6,1,2'b01,0,0,0,0);
    add(1,1,0,4'd3,1,2'b00,0, 4'd6,1,2'b01,0,0,0,0);
    add(1,1,1,4'd0,0,2'b00,0, 4'd0,0,2'b01,0,0,0,0);
    add(1,0,0,4'd0,0,2'b00,0, 4'd4,1,2'b01,0,0,0,0);
    add(1,1,1,4'd0,0,2'b00,0, 4'd0,0,2'b01,0,1,0,0);
    add(0,1,0,4'd0,0,2'b00,0, 4'd0,0,2'b01,0,0,0,0);
    // Illegal mask 00.
    add(1,1,0,4'd0,0,2'b00,0, 4'd0,0,2'b01,0,0,0,0);
    add(1,1,0,4'd1,1,2'b00,0, 4'd0,0,2'b01,0,0,0,0);
    add(1,0,0,4'd0,0,2'b00,0, 4'd2,1,2'b01,0,0,0,0);
    add(1,1,1,4'd0,0,2'b00,0, 4'd0,0,2'b01,0,0,0,0);
    add(1,1,0,4'd5,1,2'b00,0, 4'd0,0,2'b01,0,0,0,0);
    add(1,0,0,4'd0,0,2'b00,0, 4'd0,0,2'b01,0,0,1,0);
    add(1,0,1,4'd5,1,2'b11,0, 4'd0,0,2'b01,0,0,1,0);
    add(0,1,0,4'd0,0,2'b00,0, 4'd0,0,2'b01,0,0,0,0);

    rst = 1'b1;
    bus.i_en = 0; bus.i_busy_sideband = 1; bus.i_falling_edge_busy = 0;
    bus.i_rx_msg = 4'd0; bus.i_msg_valid = 0; bus.i_lane_mask = 2'b00;
    bus.i_done_repeater = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", 4'd0, 0, 2'b11, 0, 0, 0, 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      cyc(vecs[i].en, vecs[i].busy, vecs[i].feb, vecs[i].msg, vecs[i].val,
          vecs[i].mask, vecs[i].done);
      chk($sformatf("vec%0d", i), vecs[i].txm, vecs[i].txv, vecs[i].lane,
          vecs[i].sr, vecs[i].ed, vecs[i].er, vecs[i].to);
    end

    // Degrade limit: the fourth degrade_req in a pass errors out.
    to_wait_req();
    for (int k = 1; k <= 4; k++) begin
      cyc(1, 1, 0, 4'd5, 1, 2'b11, 0);
      cyc(1, 1, 0, 4'd0, 0, 2'b00, 0);
      if (k < 4) begin
        chk($sformatf("deg_limit_ok%0d", k), 4'd0, 0, 2'b01, 0, 0, 0, 0);
        cyc(1, 0, 0, 4'd0, 0, 2'b00, 0);
        cyc(1, 1, 1, 4'd0, 0, 2'b00, 0);
      end else begin
        chk("deg_limit_err", 4'd0, 0, 2'b01, 0, 0, 1, 0);
      end
    end
    cyc(0, 1, 0, 4'd0, 0, 2'b00, 0);

    // Timeout in WAIT_START_REQ after 16 cycles.
    cyc(1, 1, 0, 4'd0, 0, 2'b00, 0);
    repeat (15) cyc(1, 1, 0, 4'd0, 0, 2'b00, 0);
    chk("timeout_pre", 4'd0, 0, 2'b01, 0, 0, 0, 0);
    cyc(1, 1, 0, 4'd0, 0, 2'b00, 0);
    chk("timeout", 4'd0, 0, 2'b01, 0, 0, 1, 1);
    cyc(0, 1, 0, 4'd0, 0, 2'b00, 0);
    chk("timeout_clear", 4'd0, 0, 2'b01, 0, 0, 0, 0);

    // Abort in RUN_REP, then restart.
    to_wait_req();
    cyc(1, 1, 0, 4'd5, 1, 2'b10, 0);
    cyc(1, 1, 0, 4'd0, 0, 2'b00, 0);
    cyc(1, 0, 0, 4'd0, 0, 2'b00, 0);
    cyc(1, 1, 1, 4'd0, 0, 2'b00, 0);
    chk("run_rep_kick", 4'd0, 0, 2'b10, 1, 0, 0, 0);
    cyc(0, 1, 0, 4'd0, 0, 2'b00, 0);
    chk("abort", 4'd0, 0, 2'b10, 0, 0, 0, 0);
    cyc(1, 1, 0, 4'd0, 0, 2'b00, 0);
    cyc(1, 1, 0, 4'd1, 1, 2'b00, 0);
    cyc(1, 0, 0, 4'd0, 0, 2'b00, 0);
    chk("restart", 4'd2, 1, 2'b10, 0, 0, 0, 0);

    // Asynchronous reset between clock edges.
    rst = 1'b1;
    #1;
    chk("async_rst", 4'd0, 0, 2'b11, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
`default_nettype wire
